load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator on the CPU side of DataCache; drives its addr/MemRead/MemWrite/WriteData/funct3 pins and consumes output_data.
- Accepts one memory request at a time from the MEM stage.
- Positions store data into byte lanes, extracts and sign/zero-extends load data per funct3, and flags misaligned or illegal accesses without touching the cache.
- Returns a one-cycle response pulse; the pipeline stalls on req_ready low.

Parameters:
- CACHE_LATENCY, 1, cycles from the MemRead strobe edge until output_data is valid (1..15).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V load/store funct3.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_misaligned  out  1  valid with resp_valid.
- resp_illegal  out  1  valid with resp_valid.
- MemRead  out  1  cache read strobe.
- MemWrite  out  1  cache write strobe.
- addr  out  ADDR_W  cache byte address.
- WriteData  out  32  lane-positioned store data.
- funct3  out  3  passed to cache.
- output_data  in  32  cache word at addr[31:2].

Behaviour:
- Reset (async, immediate): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, both flags 0, MemRead=MemWrite=0, addr=0, WriteData=0, funct3=0, latency counter=0.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: req_ready=1. A request is accepted on req_valid&&req_ready, and all req_* fields are registered.
  - If the request is illegal or misaligned, next state is RESP with no cache strobe.
  - Otherwise, next state is ACCESS.
- ACCESS: exactly one cycle. MemRead=!we and MemWrite=we; addr, funct3 and WriteData are held stable. Counter is loaded with CACHE_LATENCY-1.
  - Store: next state is RESP.
  - Load: next state is WAIT.
- WAIT: counter decrements each cycle. When counter==0, output_data is captured and extended, and next state is RESP. Strobes are low throughout WAIT; addr and funct3 stay held.
- RESP: resp_valid=1 for one cycle, then IDLE. req_ready=0 in every state except IDLE.
- Latency, from the accept edge to the cycle resp_valid is high:
  - error: 1 cycle;
  - store: 2 cycles;
  - load: CACHE_LATENCY+2 cycles.
- Illegal funct3:
  - load: 011, 110, 111;
  - store: any of 011..111.
- Misaligned:
  - half (001/101) with addr[0]=1;
  - word (010) with addr[1:0]!=0.
  - If both apply, illegal=1 and misaligned=0.
- Store lanes: SB replicates the byte ×4; SH replicates the half ×2; SW passes through.
- Load extraction:
  - byte = output_data[8*addr[1:0] +: 8];
  - half = output_data[16*addr[1] +: 16];
  - 000/001 sign-extend, 100/101 zero-extend, 010 full word.
- resp_rdata/flags hold their last values after resp_valid falls; consumers sample only on resp_valid.
- req_valid outside IDLE is ignored and not queued.
- Reset mid-operation aborts the access; no response is issued for it.

Optional Feature:
- Macro LSU_PERF_CNT_EN.
- Defined:
  - adds outputs perf_loads, perf_stores, perf_errors (32 bits each, saturating at 0xFFFFFFFF, reset 0);
  - each counter increments in the RESP cycle of the corresponding completion; an error counts only in perf_errors.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then LW addr=0x00000010, CACHE_LATENCY=1, cache returns 0xDEADBEEF:
  - MemRead high exactly 1 cycle with addr=0x10, funct3=010;
  - resp_valid on cycle 3 after accept, resp_rdata=0xDEADBEEF, flags 0.
- LB addr=0x13, output_data=0x80FF7F01 → resp_rdata=0xFFFFFF80.
  - LBU same → 0x00000080.
  - LH addr=0x12 → 0xFFFF80FF.
  - LHU addr=0x12 → 0x000080FF.
- SB addr=0x21, wdata=0x123456AB → MemWrite 1 cycle, WriteData=0xABABABAB, addr=0x21.
  - resp_valid 2 cycles after accept, rdata=0.
  - SH → WriteData=0x56AB56AB.
- Error cases, each giving resp_valid 1 cycle after accept with no MemRead/MemWrite ever asserted:
  - LW addr=0x22 → misaligned=1;
  - store funct3=100 → illegal=1;
  - load funct3=011, addr=0x1 → illegal=1, misaligned=0.
- CACHE_LATENCY=4, back-to-back req_valid held high:
  - req_ready low for 6 cycles per load;
  - second request accepted the cycle after RESP;
  - no strobe overlap.
- rst_n driven low during WAIT:
  - immediate MemRead=0 and state IDLE;
  - no resp_valid;
  - with LSU_PERF_CNT_EN, all counters read 0.

Source files
------------

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - MEM-stage request/response and DataCache pin bundle for the load/store unit
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_misaligned;
  logic              resp_illegal;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       WriteData;
  logic [2:0]        funct3;
  logic [31:0]       output_data;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, output_data,
    output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
    output MemRead, MemWrite, addr, WriteData, funct3
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, output_data,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
    input  MemRead, MemWrite, addr, WriteData, funct3
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit driving DataCache (LSU_PERF_CNT_EN adds perf counters)
module load_store_unit #(
  parameter int CACHE_LATENCY = 1,
  parameter int ADDR_W        = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  load_store_unit_if.master   bus
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]         perf_loads,
  output logic [31:0]         perf_stores,
  output logic [31:0]         perf_errors
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t            state, state_next;
  logic              we_q;
  logic              err_q;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_next;
  logic              req_illegal;
  logic              req_misaligned;
  logic              half_op;
  logic              word_op;
  logic [31:0]       lane_data;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [31:0]       load_data;

  // Classify the incoming request; illegal wins over misaligned.
  always_comb begin
    addr_next = bus.req_addr;
    half_op   = (bus.req_funct3[1:0] == 2'b01);
    word_op   = (bus.req_funct3 == 3'b010);
    if (bus.req_we)
      req_illegal = (bus.req_funct3 >= 3'b011);
    else
      req_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                    (bus.req_funct3 == 3'b111);
    req_misaligned = !req_illegal &&
                     ((half_op && addr_next[0]) || (word_op && (addr_next[1:0] != 2'b00)));
    case (bus.req_funct3[1:0])
      2'b00:   lane_data = {4{bus.req_wdata[7:0]}};
      2'b01:   lane_data = {2{bus.req_wdata[15:0]}};
      default: lane_data = bus.req_wdata;
    endcase
  end

  always_comb begin
    load_byte = 8'(bus.output_data >> {bus.addr[1:0], 3'b000});
    load_half = 16'(bus.output_data >> {bus.addr[1], 4'b0000});
    case (bus.funct3)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b100:  load_data = {24'h0, load_byte};
      3'b101:  load_data = {16'h0, load_half};
      default: load_data = bus.output_data;
    endcase
  end

  always_comb begin
    state_next     = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid)
          state_next = (req_illegal || req_misaligned) ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.MemRead  = !we_q;
        bus.MemWrite = we_q;
        state_next   = we_q ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0)
          state_next = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      we_q                <= 1'b0;
      err_q               <= 1'b0;
      cnt                 <= 4'd0;
      bus.addr            <= '0;
      bus.funct3          <= 3'b000;
      bus.WriteData       <= 32'h0;
      bus.resp_rdata      <= 32'h0;
      bus.resp_misaligned <= 1'b0;
      bus.resp_illegal    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q          <= bus.req_we;
            err_q         <= req_illegal || req_misaligned;
            bus.addr      <= addr_next;
            bus.funct3    <= bus.req_funct3;
            bus.WriteData <= lane_data;
            if (req_illegal || req_misaligned) begin
              bus.resp_rdata      <= 32'h0;
              bus.resp_illegal    <= req_illegal;
              bus.resp_misaligned <= req_misaligned;
            end
          end
        end
        ACCESS: begin
          cnt <= 4'(CACHE_LATENCY - 1);
          if (we_q) begin
            bus.resp_rdata      <= 32'h0;
            bus.resp_illegal    <= 1'b0;
            bus.resp_misaligned <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            bus.resp_rdata      <= load_data;
            bus.resp_illegal    <= 1'b0;
            bus.resp_misaligned <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loads  <= 32'h0;
      perf_stores <= 32'h0;
      perf_errors <= 32'h0;
    end else if (state == RESP) begin
      if (err_q) begin
        if (perf_errors != 32'hFFFF_FFFF) perf_errors <= perf_errors + 32'd1;
      end else if (we_q) begin
        if (perf_stores != 32'hFFFF_FFFF) perf_stores <= perf_stores + 32'd1;
      end else begin
        if (perf_loads != 32'hFFFF_FFFF) perf_loads <= perf_loads + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit at cache latencies 1 and 4
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) if1 ();
  load_store_unit_if #(.ADDR_W(32)) if4 ();

`ifdef LSU_PERF_CNT_EN
  logic [31:0] pl1, ps1, pe1, pl4, ps4, pe4;
`endif

  load_store_unit #(.CACHE_LATENCY(1), .ADDR_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
`ifdef LSU_PERF_CNT_EN
    , .perf_loads(pl1), .perf_stores(ps1), .perf_errors(pe1)
`endif
  );

  load_store_unit #(.CACHE_LATENCY(4), .ADDR_W(32)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4)
`ifdef LSU_PERF_CNT_EN
    , .perf_loads(pl4), .perf_stores(ps4), .perf_errors(pe4)
`endif
  );

  int          r_k, r_nr, r_nw;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [2:0]  r_f3;
  logic        r_mis, r_ill, r_after_v;

  // Issue one request on the latency-1 unit and record what the cache and response sides did.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] od);
    @(negedge clk);
    if1.req_we = we; if1.req_funct3 = f3; if1.req_addr = a;
    if1.req_wdata = wd; if1.output_data = od; if1.req_valid = 1'b1;
    @(posedge clk);
    #1 if1.req_valid = 1'b0;
    r_k = 0; r_nr = 0; r_nw = 0; r_addr = 'x; r_wdata = 'x; r_f3 = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (if1.MemRead)  begin r_nr++; r_addr = if1.addr; r_f3 = if1.funct3; end
      if (if1.MemWrite) begin r_nw++; r_addr = if1.addr; r_f3 = if1.funct3; r_wdata = if1.WriteData; end
      if (if1.resp_valid) begin
        r_k = k; r_rdata = if1.resp_rdata; r_mis = if1.resp_misaligned; r_ill = if1.resp_illegal;
        break;
      end
    end
    @(negedge clk);
    r_after_v = if1.resp_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    if1.req_valid = 0; if1.req_we = 0; if1.req_funct3 = 0; if1.req_addr = 0; if1.req_wdata = 0; if1.output_data = 0;
    if4.req_valid = 0; if4.req_we = 0; if4.req_funct3 = 0; if4.req_addr = 0; if4.req_wdata = 0; if4.output_data = 0;
    repeat (3) @(negedge clk);
    total++; if (if1.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", if1.req_ready); end
    total++; if ({if1.resp_valid, if1.resp_misaligned, if1.resp_illegal, if1.MemRead, if1.MemWrite} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {if1.resp_valid, if1.resp_misaligned, if1.resp_illegal, if1.MemRead, if1.MemWrite}); end
    total++; if ({if1.resp_rdata, if1.addr, if1.WriteData, if1.funct3} !== 99'h0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", if1.resp_rdata, if1.addr, if1.WriteData, if1.funct3); end
    rst_n = 1'b1;
  endtask

  task automatic test_lw;
    run_op(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF);
    total++; if (r_nr !== 1 || r_nw !== 0) begin bad++; $display("FAIL lw_strobe got=rd%0d/wr%0d exp=rd1/wr0", r_nr, r_nw); end
    total++; if (r_addr !== 32'h10 || r_f3 !== 3'b010) begin bad++; $display("FAIL lw_pins got=%h/%b exp=00000010/010", r_addr, r_f3); end
    total++; if (r_k !== 3) begin bad++; $display("FAIL lw_latency got=%0d exp=3", r_k); end
    total++; if (r_rdata !== 32'hDEADBEEF || r_mis !== 1'b0 || r_ill !== 1'b0) begin
      bad++; $display("FAIL lw_resp got=%h m%b i%b exp=deadbeef m0 i0", r_rdata, r_mis, r_ill); end
    total++; if (r_after_v !== 1'b0) begin bad++; $display("FAIL lw_pulse got=%b exp=0", r_after_v); end
  endtask

  task automatic test_load_ext;
    logic [2:0]  f3 [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001};
    logic [31:0] ad [6] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h11, 32'h10};
    logic [31:0] ex [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h0000007F, 32'h00007F01};
    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, f3[i], ad[i], 32'h0, 32'h80FF7F01);
      total++; if (r_rdata !== ex[i] || r_k !== 3 || r_nr !== 1) begin
        bad++; $display("FAIL load_ext_%0d got=%h lat%0d rd%0d exp=%h lat3 rd1", i, r_rdata, r_k, r_nr, ex[i]); end
    end
  endtask

  task automatic test_errors;
    logic        we [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f3 [6] = '{3'b010, 3'b100, 3'b011, 3'b001, 3'b101, 3'b110};
    logic [31:0] ad [6] = '{32'h22, 32'h20, 32'h01, 32'h21, 32'h03, 32'h00};
    logic        em [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        ei [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      run_op(we[i], f3[i], ad[i], 32'hCAFEF00D, 32'h12345678);
      total++; if (r_k !== 1 || r_nr !== 0 || r_nw !== 0) begin
        bad++; $display("FAIL err_%0d_timing got=lat%0d rd%0d wr%0d exp=lat1 rd0 wr0", i, r_k, r_nr, r_nw); end
      total++; if (r_mis !== em[i] || r_ill !== ei[i] || r_rdata !== 32'h0) begin
        bad++; $display("FAIL err_%0d_flags got=m%b i%b %h exp=m%b i%b 0", i, r_mis, r_ill, r_rdata, em[i], ei[i]); end
    end
  endtask

  task automatic test_store;
    logic [2:0]  f3 [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] ad [3] = '{32'h21, 32'h22, 32'h24};
    logic [31:0] ex [3] = '{32'hABABABAB, 32'h56AB56AB, 32'h123456AB};
    run_op(1'b0, 3'b010, 32'h30, 32'h0, 32'h55AA55AA);
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, f3[i], ad[i], 32'h123456AB, 32'h55AA55AA);
      total++; if (r_nw !== 1 || r_nr !== 0 || r_wdata !== ex[i] || r_addr !== ad[i]) begin
        bad++; $display("FAIL store_%0d got=wr%0d rd%0d %h @%h exp=wr1 rd0 %h @%h", i, r_nw, r_nr, r_wdata, r_addr, ex[i], ad[i]); end
      total++; if (r_k !== 2 || r_rdata !== 32'h0 || r_mis !== 1'b0 || r_ill !== 1'b0) begin
        bad++; $display("FAIL store_%0d_resp got=lat%0d %h exp=lat2 0", i, r_k, r_rdata); end
    end
`ifdef LSU_PERF_CNT_EN
    total++; if (pl1 !== 32'd8 || ps1 !== 32'd3 || pe1 !== 32'd6) begin
      bad++; $display("FAIL perf_counts got=%0d/%0d/%0d exp=8/3/6", pl1, ps1, pe1); end
`endif
  endtask

  task automatic test_back_to_back;
    int na = 0, nresp = 0, nruns = 0, lowrun = 0, nrd = 0, ovl = 0;
    int acc [2] = '{-1, -1};
    int rsp [2] = '{-1, -1};
    int runs [2] = '{-1, -1};
    logic [31:0] rd [2] = '{32'h0, 32'h0};
    @(negedge clk);
    if4.req_we = 1'b0; if4.req_funct3 = 3'b000; if4.req_addr = 32'h13;
    if4.output_data = 32'h80FF7F01; if4.req_valid = 1'b1;
    for (int c = 0; c < 17; c++) begin
      if (if4.req_ready && if4.req_valid) begin
        if (na < 2) acc[na] = c;
        na++;
      end else if (!if4.req_ready && na == 1) begin
        if4.req_addr = 32'h10; if4.req_funct3 = 3'b101;
      end else if (!if4.req_ready && na >= 2) begin
        if4.req_valid = 1'b0;
      end
      if (if4.resp_valid) begin
        if (nresp < 2) begin rsp[nresp] = c; rd[nresp] = if4.resp_rdata; end
        nresp++;
      end
      if (!if4.req_ready) lowrun++;
      else if (lowrun > 0) begin
        if (nruns < 2) runs[nruns] = lowrun;
        nruns++; lowrun = 0;
      end
      if (if4.MemRead) nrd++;
      if (if4.MemRead && if4.MemWrite) ovl++;
      @(negedge clk);
    end
    total++; if (na !== 2 || acc[0] !== 0 || acc[1] !== 7) begin
      bad++; $display("FAIL b2b_accept got=n%0d %0d,%0d exp=n2 0,7", na, acc[0], acc[1]); end
    total++; if (nresp !== 2 || rsp[0] !== 6 || rsp[1] !== 13) begin
      bad++; $display("FAIL b2b_resp got=n%0d %0d,%0d exp=n2 6,13", nresp, rsp[0], rsp[1]); end
    total++; if (runs[0] !== 6 || runs[1] !== 6) begin
      bad++; $display("FAIL b2b_stall got=%0d,%0d exp=6,6", runs[0], runs[1]); end
    total++; if (nrd !== 2 || ovl !== 0) begin bad++; $display("FAIL b2b_strobe got=rd%0d ovl%0d exp=rd2 ovl0", nrd, ovl); end
    total++; if (rd[0] !== 32'hFFFFFF80 || rd[1] !== 32'h00007F01) begin
      bad++; $display("FAIL b2b_data got=%h,%h exp=ffffff80,00007f01", rd[0], rd[1]); end
  endtask

  task automatic test_reset_mid;
    int nv = 0;
    @(negedge clk);
    if4.req_we = 1'b0; if4.req_funct3 = 3'b010; if4.req_addr = 32'h40; if4.req_valid = 1'b1;
    @(posedge clk);
    #1 if4.req_valid = 1'b0;
    @(negedge clk);
    total++; if (if4.MemRead !== 1'b1) begin bad++; $display("FAIL mid_access_rd got=%b exp=1", if4.MemRead); end
    @(negedge clk);
    total++; if (if4.MemRead !== 1'b0 || if4.req_ready !== 1'b0) begin
      bad++; $display("FAIL mid_wait got=rd%b rdy%b exp=rd0 rdy0", if4.MemRead, if4.req_ready); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (if4.MemRead !== 1'b0 || if4.req_ready !== 1'b1 || if4.addr !== 32'h0) begin
      bad++; $display("FAIL mid_reset got=rd%b rdy%b %h exp=rd0 rdy1 0", if4.MemRead, if4.req_ready, if4.addr); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (if4.resp_valid) nv++;
    end
    total++; if (nv !== 0) begin bad++; $display("FAIL mid_no_resp got=%0d exp=0", nv); end
`ifdef LSU_PERF_CNT_EN
    total++; if ({pl4, ps4, pe4, pl1, ps1, pe1} !== 192'h0) begin
      bad++; $display("FAIL mid_perf got=%0d/%0d/%0d exp=0/0/0", pl4, ps4, pe4); end
`endif
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_errors();
    test_store();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
